maj_vote_arbiter: RTL

Round-robin arbiter and sequencer that shares a single 4-input majority voter among `N_REQ` requesters. Each requester presents a 4-bit vote word with a request. The block grants one requester at a time, latches its word, and evaluates strict majority (≥3 of 4 ones). It then returns the result, tagged with the requester ID, over a valid/ready handshake. It sits between the sample-capture front ends and the downstream decision logic.

---
 rtl/maj_arb_pkg.sv | 12 +
 rtl/maj4_core.sv | 29 ++
 rtl/maj_vote_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/maj_arb_pkg.sv
// Shared constants for the round-robin majority-vote arbiter.
// State encoding, default requester count and vote-word width.
package maj_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EVAL = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int N_REQ_DEF = 4;
  localparam int VOTE_W    = 4;

endpackage

// File: rtl/maj4_core.sv
// Combinational 4-input strict-majority voter (>=3 ones).
// Optional tie output under MAJ_ARB_TIE_FLAG_EN (exactly two ones).
module maj4_core
  import maj_arb_pkg::*;
(
  input  logic [VOTE_W-1:0] word,
  output logic              maj
`ifdef MAJ_ARB_TIE_FLAG_EN
  ,
  output logic              tie
`endif
);

  logic [2:0] ones;

  // Population count of the vote word
  always_comb begin
    ones = 3'd0;
    for (int i = 0; i < VOTE_W; i++) begin
      ones = ones + {2'b00, word[i]};
    end
  end

  assign maj = (ones >= 3'd3);
`ifdef MAJ_ARB_TIE_FLAG_EN
  assign tie = (ones == 3'd2);
`endif

endmodule

// File: rtl/maj_vote_arbiter.sv
// Round-robin arbiter sharing one majority voter among N_REQ requesters.
// Optional res_tie output under MAJ_ARB_TIE_FLAG_EN.
module maj_vote_arbiter
  import maj_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [VOTE_W*N_REQ-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
`ifdef MAJ_ARB_TIE_FLAG_EN
  output logic                    res_tie,
`endif
  output logic                    res_bit
);

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [VOTE_W-1:0] word_q, word_d;
  logic              bit_q, bit_d;
  logic              found;
  logic [ID_W-1:0]   win;
  logic [ID_W:0]     cand;
  logic [ID_W:0]     nxt;
  logic [VOTE_W-1:0] sel_word;
  logic              vote_maj;
  logic              idle;
  logic              xfer;
`ifdef MAJ_ARB_TIE_FLAG_EN
  logic              tie_q, tie_d;
  logic              vote_tie;
`endif

  maj4_core u_core (
    .word (word_q),
`ifdef MAJ_ARB_TIE_FLAG_EN
    .tie  (vote_tie),
`endif
    .maj  (vote_maj)
  );

  assign idle = (state_q == ST_IDLE);
  assign xfer = res_valid && res_ready;

  // First pending requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  // Vote word of the current winner
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == ID_W'(k)) begin
        sel_word = data[k*VOTE_W +: VOTE_W];
      end
    end
  end

  // One-hot grant, only in IDLE and never while reset is held
  always_comb begin
    gnt = '0;
    if (idle && found && !rst) begin
      gnt[win] = 1'b1;
    end
  end

  assign res_valid = (state_q == ST_DONE) && !rst;
  assign res_id    = id_q;
  assign res_bit   = bit_q;
`ifdef MAJ_ARB_TIE_FLAG_EN
  assign res_tie   = tie_q;
`endif

  // Next pointer: one past the served requester
  always_comb begin
    nxt = {1'b0, id_q} + {{ID_W{1'b0}}, 1'b1};
    if (nxt == (ID_W+1)'(N_REQ)) begin
      nxt = '0;
    end
  end

  // Sequencer: grant/latch, evaluate, hand off result
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    word_d  = word_q;
    bit_d   = bit_q;
`ifdef MAJ_ARB_TIE_FLAG_EN
    tie_d   = tie_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          id_d    = win;
          word_d  = sel_word;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        bit_d   = vote_maj;
`ifdef MAJ_ARB_TIE_FLAG_EN
        tie_d   = vote_tie;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (xfer) begin
          ptr_d   = nxt[ID_W-1:0];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      word_q  <= '0;
      bit_q   <= 1'b0;
`ifdef MAJ_ARB_TIE_FLAG_EN
      tie_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
`ifdef MAJ_ARB_TIE_FLAG_EN
      tie_q   <= tie_d;
`endif
    end
  end

endmodule
